// File: rtl/pe_stride.sv
// pe_stride: row-stationary processing element. It loads an activation row
// and a filter row into local scratchpads, runs a strided 1-D convolution
// one MAC per cycle, then streams the partial sums to the psum chain through
// a ready/valid handshake.
// Optional feature: define PE_SAT_ACC_EN for saturating accumulation and
// psum addition. When it is undefined, both wrap modulo 2^PSUM_W.
// The depth parameters are assumed to be at most 255 (8-bit row-length fields).
module pe_stride #(
  parameter int DATA_W  = 8,
  parameter int A_DEPTH = 16,
  parameter int W_DEPTH = 16,
  parameter int PSUM_W  = 2*DATA_W+4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic signed [DATA_W-1:0] weights_i,
  input  logic signed [DATA_W-1:0] acts_i,
  input  logic                     ctrl_loadw,
  input  logic                     ctrl_loada,
  input  logic                     ctrl_start,
  input  logic                     ctrl_sums,
  input  logic [7:0]               cfg_acount,
  input  logic [7:0]               cfg_wcount,
  input  logic [3:0]               cfg_stride,
  input  logic signed [PSUM_W-1:0] psum_i,
  input  logic                     psum_valid_i,
  output logic signed [PSUM_W-1:0] psum_o,
  output logic                     psum_valid_o,
  input  logic                     psum_ready_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int AW = (A_DEPTH > 1) ? $clog2(A_DEPTH) : 1;    // activation / psum index
  localparam int KW = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;    // weight index
  localparam int LA = $clog2(A_DEPTH + 1);                    // load address, may reach depth
  localparam int LW = $clog2(W_DEPTH + 1);
  localparam int IW = $clog2(A_DEPTH + 1);                    // sums index, may reach ocount

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE, SUMS} state_t;

  state_t state, state_n;

  logic signed [DATA_W-1:0] a_mem [A_DEPTH];
  logic signed [DATA_W-1:0] w_mem [W_DEPTH];
  logic signed [PSUM_W-1:0] s_mem [A_DEPTH];

  logic [LA-1:0] aaddr;
  logic [LW-1:0] waddr;
  logic [KW-1:0] k;
  logic [AW-1:0] o;
  logic [AW-1:0] base;            // o*stride, kept as a running sum
  logic [IW-1:0] idx;
  logic [7:0]    wcount_q;
  logic [7:0]    ocount_q;
  logic [3:0]    stride_q;
  logic signed [PSUM_W-1:0] acc;

  // Saturating or wrapping PSUM_W-bit addition.
  function automatic logic signed [PSUM_W-1:0] acc_add(input logic signed [PSUM_W-1:0] x,
                                                       input logic signed [PSUM_W-1:0] y);
`ifdef PE_SAT_ACC_EN
    logic signed [PSUM_W:0] full;
    full = {x[PSUM_W-1], x} + {y[PSUM_W-1], y};
    if (full[PSUM_W] != full[PSUM_W-1])
      return full[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
    return full[PSUM_W-1:0];
`else
    return x + y;
`endif
  endfunction

  // Start qualification and ocount computation; the divisor is forced
  // non-zero so a rejected stride of 0 never reaches the divider.
  logic       start_req, cfg_bad;
  logic [3:0] div;
  logic [7:0] ocount_calc;
  assign start_req   = ctrl_start && !ctrl_loadw && !ctrl_loada;
  assign cfg_bad     = (cfg_wcount == 8'd0) || (cfg_stride == 4'd0) ||
                       (cfg_wcount > cfg_acount) || (cfg_acount > 8'(A_DEPTH)) ||
                       (cfg_wcount > 8'(W_DEPTH));
  assign div         = (cfg_stride == 4'd0) ? 4'd1 : cfg_stride;
  assign ocount_calc = ((cfg_acount - cfg_wcount) / {4'd0, div}) + 8'd1;

  // MAC datapath: full-precision product, sign-extended to psum width.
  logic [AW-1:0]              aidx;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [PSUM_W-1:0]   prod_ext, mac_sum, sum_out;
  logic                       k_last, o_last, xfer, sums_end;
  assign aidx     = base + AW'(k);
  assign prod     = a_mem[aidx] * w_mem[k];
  assign prod_ext = {{(PSUM_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign mac_sum  = acc_add(acc, prod_ext);
  assign sum_out  = acc_add(s_mem[idx[AW-1:0]], psum_i);
  assign k_last   = (8'(k) == wcount_q - 8'd1);
  assign o_last   = (8'(o) == ocount_q - 8'd1);
  assign xfer     = (state == SUMS) && psum_valid_i && (!psum_valid_o || psum_ready_i) &&
                    (8'(idx) != ocount_q);
  assign sums_end = (8'(idx) == ocount_q) && (!psum_valid_o || psum_ready_i);

  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (!nrst) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic; start takes priority over sums.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_n unassigned (no latch).
    state_n = state;
    case (state)
      IDLE: begin
        if (start_req) begin
          if (!cfg_bad) state_n = COMPUTE;
        end else if (ctrl_sums) begin
          state_n = SUMS;
        end
      end
      COMPUTE: if (k_last && o_last) state_n = DONE;
      DONE:    state_n = IDLE;
      SUMS:    if (sums_end) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // Scratchpads, counters, MAC accumulator and psum output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      // NOTE: scratchpads are cleared by reset, so they are built from flops, not RAM macros.
      for (int i = 0; i < A_DEPTH; i++) begin
        a_mem[i] <= '0;
        s_mem[i] <= '0;
      end
      for (int i = 0; i < W_DEPTH; i++) w_mem[i] <= '0;
      aaddr        <= '0;
      waddr        <= '0;
      k            <= '0;
      o            <= '0;
      base         <= '0;
      idx          <= '0;
      wcount_q     <= '0;
      ocount_q     <= '0;
      stride_q     <= '0;
      acc          <= '0;
      psum_o       <= '0;
      psum_valid_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      err_o <= 1'b0;

      // Weight / activation streaming loads; the address sticks at depth.
      if (state == IDLE && ctrl_loadw) begin
        if (waddr != LW'(W_DEPTH)) begin
          w_mem[waddr[KW-1:0]] <= weights_i;
          waddr                <= waddr + LW'(1);
        end
      end else begin
        waddr <= '0;
      end
      if (state == IDLE && ctrl_loada) begin
        if (aaddr != LA'(A_DEPTH)) begin
          a_mem[aaddr[AW-1:0]] <= acts_i;
          aaddr                <= aaddr + LA'(1);
        end
      end else begin
        aaddr <= '0;
      end

      case (state)
        IDLE: begin
          if (start_req) begin
            if (cfg_bad) begin
              err_o <= 1'b1;
            end else begin
              wcount_q <= cfg_wcount;
              stride_q <= cfg_stride;
              ocount_q <= ocount_calc;
              k        <= '0;
              o        <= '0;
              base     <= '0;
              acc      <= '0;
            end
          end else if (ctrl_sums) begin
            idx <= '0;
          end
        end
        COMPUTE: begin
          if (k_last) begin
            s_mem[o] <= mac_sum;
            acc      <= '0;
            k        <= '0;
            o        <= o + AW'(1);
            base     <= base + AW'(stride_q);
          end else begin
            acc <= mac_sum;
            k   <= k + KW'(1);
          end
        end
        SUMS: begin
          if (xfer) begin
            psum_o             <= sum_out;
            s_mem[idx[AW-1:0]] <= sum_out;
            psum_valid_o       <= 1'b1;
            idx                <= idx + IW'(1);
          end else if (psum_valid_o && psum_ready_i) begin
            psum_valid_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_stride.sv
// tb_pe_stride: directed and randomized checks of pe_stride against a
// convolution reference model held as plain arrays.
module tb_pe_stride;

  localparam int DATA_W  = 8;
  localparam int A_DEPTH = 16;
  localparam int W_DEPTH = 16;
  localparam int PSUM_W  = 2*DATA_W+4;

  logic                     clk = 1'b0;
  logic                     nrst = 1'b0;
  logic signed [DATA_W-1:0] weights_i = '0;
  logic signed [DATA_W-1:0] acts_i = '0;
  logic                     ctrl_loadw = 1'b0, ctrl_loada = 1'b0;
  logic                     ctrl_start = 1'b0, ctrl_sums = 1'b0;
  logic [7:0]               cfg_acount = '0, cfg_wcount = '0;
  logic [3:0]               cfg_stride = '0;
  logic signed [PSUM_W-1:0] psum_i = '0;
  logic                     psum_valid_i = 1'b0;
  logic signed [PSUM_W-1:0] psum_o;
  logic                     psum_valid_o;
  logic                     psum_ready_i = 1'b0;
  logic                     busy_o, done_o, err_o;

  pe_stride #(.DATA_W(DATA_W), .A_DEPTH(A_DEPTH), .W_DEPTH(W_DEPTH), .PSUM_W(PSUM_W)) dut (
    .clk(clk), .nrst(nrst), .weights_i(weights_i), .acts_i(acts_i),
    .ctrl_loadw(ctrl_loadw), .ctrl_loada(ctrl_loada), .ctrl_start(ctrl_start),
    .ctrl_sums(ctrl_sums), .cfg_acount(cfg_acount), .cfg_wcount(cfg_wcount),
    .cfg_stride(cfg_stride), .psum_i(psum_i), .psum_valid_i(psum_valid_i),
    .psum_o(psum_o), .psum_valid_o(psum_valid_o), .psum_ready_i(psum_ready_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: rows, stored psums, and ocount of the last accepted start.
  int     a_m [A_DEPTH];
  int     w_m [W_DEPTH];
  longint s_m [A_DEPTH];
  int     oc_m = 0;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Psum-width arithmetic of the reference: clamp or wrap.
  function automatic longint fix(input longint v);
`ifdef PE_SAT_ACC_EN
    longint hi = (longint'(1) <<< (PSUM_W-1)) - 1;
    longint lo = -(longint'(1) <<< (PSUM_W-1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    logic signed [PSUM_W-1:0] t;
    t = v[PSUM_W-1:0];
    return longint'(t);
`endif
  endfunction

  task automatic load_rows(input int na, input int nw);
    for (int i = 0; i < nw; i++) begin
      weights_i  = w_m[i][DATA_W-1:0];
      ctrl_loadw = 1'b1;
      tick();
    end
    ctrl_loadw = 1'b0;
    tick();
    for (int i = 0; i < na; i++) begin
      acts_i     = a_m[i][DATA_W-1:0];
      ctrl_loada = 1'b1;
      tick();
    end
    ctrl_loada = 1'b0;
    tick();
  endtask

  task automatic reject_start(input string tag, input int na, input int nw, input int st);
    cfg_acount = 8'(na);
    cfg_wcount = 8'(nw);
    cfg_stride = 4'(st);
    ctrl_start = 1'b1;
    tick();
    ctrl_start = 1'b0;
    check({tag, " err_pulse"}, err_o, 1);
    check({tag, " busy"}, busy_o, 0);
    tick();
    check({tag, " err_clear"}, err_o, 0);
    check({tag, " busy_after"}, busy_o, 0);
  endtask

  // Start a convolution and check busy, done latency and single-cycle done.
  task automatic run_compute(input string tag, input int na, input int nw, input int st);
    int cyc;
    oc_m = (na - nw) / st + 1;
    for (int o = 0; o < oc_m; o++) begin
      longint acc = 0;
      for (int k = 0; k < nw; k++) acc = fix(acc + longint'(a_m[o*st + k] * w_m[k]));
      s_m[o] = acc;
    end
    cfg_acount = 8'(na);
    cfg_wcount = 8'(nw);
    cfg_stride = 4'(st);
    ctrl_start = 1'b1;
    tick();
    ctrl_start = 1'b0;
    check({tag, " busy"}, busy_o, 1);
    cyc = 1;
    while (!done_o && cyc < 2000) begin
      tick();
      cyc++;
    end
    check({tag, " done_latency"}, cyc, oc_m*nw + 1);
    tick();
    check({tag, " done_single"}, done_o, 0);
    check({tag, " idle"}, busy_o, 0);
  endtask

  // Stream the psums. mode 0: ready always high; 1: ready low for the first
  // two cycles with valid high; 2: random ready.
  task automatic run_sums(input string tag, input longint p, input int mode);
    longint exp_q[$];
    int     n_out = 0, stall_left = 2, c = 1;
    bit     held = 1'b0, seen_done = 1'b0, r;
    logic signed [PSUM_W-1:0] held_val = '0;
    for (int o = 0; o < oc_m; o++) begin
      s_m[o] = fix(s_m[o] + p);
      exp_q.push_back(s_m[o]);
    end
    psum_i       = PSUM_W'(p);
    psum_valid_i = 1'b1;
    psum_ready_i = (mode == 0);
    ctrl_sums    = 1'b1;
    tick();
    ctrl_sums = 1'b0;
    while (!seen_done && c < 500) begin
      if (held) begin
        check({tag, " hold_data"}, psum_o, held_val);
        check({tag, " hold_valid"}, psum_valid_o, 1);
      end
      if (done_o) begin
        seen_done = 1'b1;
      end else begin
        case (mode)
          0:       r = 1'b1;
          1:       r = (stall_left == 0);
          default: r = 1'($urandom_range(0, 1));
        endcase
        psum_ready_i = r;
        held = 1'b0;
        if (psum_valid_o && r) begin
          if (exp_q.size() > 0) check({tag, " psum"}, psum_o, exp_q.pop_front());
          else                  check({tag, " extra_valid"}, psum_valid_o, 0);
          n_out++;
        end else if (psum_valid_o) begin
          held     = 1'b1;
          held_val = psum_o;
          if (mode == 1 && stall_left > 0) stall_left--;
        end
        tick();
        c++;
      end
    end
    check({tag, " done_seen"}, seen_done, 1);
    check({tag, " count"}, n_out, oc_m);
    if (mode == 0) check({tag, " throughput"}, c, oc_m + 2);
    psum_valid_i = 1'b0;
    psum_ready_i = 1'b0;
    tick();
    check({tag, " done_single"}, done_o, 0);
    check({tag, " valid_low"}, psum_valid_o, 0);
  endtask

  task automatic set_case1();
    for (int i = 0; i < 5; i++) a_m[i] = i + 1;
    for (int i = 0; i < 3; i++) w_m[i] = 1;
  endtask

  initial begin
    // Reset state.
    tick();
    tick();
    check("rst psum_o", psum_o, 0);
    check("rst psum_valid_o", psum_valid_o, 0);
    check("rst busy_o", busy_o, 0);
    check("rst done_o", done_o, 0);
    check("rst err_o", err_o, 0);
    for (int i = 0; i < A_DEPTH; i++) s_m[i] = 0;
    nrst = 1'b1;
    tick();

    // Sums before any start: ocount is 0, done pulses with no output.
    run_sums("sums_empty", 5, 0);

    // Rejected starts.
    reject_start("rej_wcount0", 5, 0, 1);
    reject_start("rej_w_gt_a", 3, 4, 1);
    reject_start("rej_stride0", 5, 3, 0);
    reject_start("rej_a_depth", 17, 3, 1);

    // Unit stride, then backpressured sums: 106 (held), 109, 112.
    set_case1();
    load_rows(5, 3);
    run_compute("unit", 5, 3, 1);
    run_sums("unit_bp", 100, 1);

    // Stride 2 with filter 1,0,-1: three outputs of -2.
    for (int i = 0; i < 7; i++) a_m[i] = i + 1;
    w_m[0] = 1; w_m[1] = 0; w_m[2] = -1;
    load_rows(7, 3);
    run_compute("stride2", 7, 3, 2);
    run_sums("stride2_sums", 0, 0);

    // Reset in the middle of a computation.
    set_case1();
    load_rows(5, 3);
    cfg_acount = 8'd5; cfg_wcount = 8'd3; cfg_stride = 4'd1;
    ctrl_start = 1'b1;
    tick();
    ctrl_start = 1'b0;
    tick();
    tick();
    tick();
    nrst = 1'b0;
    #1;
    check("midrst psum_o", psum_o, 0);
    check("midrst psum_valid_o", psum_valid_o, 0);
    check("midrst busy_o", busy_o, 0);
    check("midrst done_o", done_o, 0);
    check("midrst err_o", err_o, 0);
    for (int i = 0; i < A_DEPTH; i++) s_m[i] = 0;
    oc_m = 0;
    tick();
    nrst = 1'b1;
    tick();
    check("midrst no_done", done_o, 0);
    check("midrst idle", busy_o, 0);
    load_rows(5, 3);
    run_compute("after_rst", 5, 3, 1);
    run_sums("after_rst_sums", 100, 0);

    // Saturation / wrap of the psum addition: 262144 + 300000.
    for (int i = 0; i < 16; i++) begin
      a_m[i] = -128;
      w_m[i] = -128;
    end
    load_rows(16, 16);
    run_compute("sat", 16, 16, 1);
    run_sums("sat_sums", 300000, 0);

    // Randomized configurations, data and backpressure.
    for (int it = 0; it < 8; it++) begin
      int na, nw, st;
      na = int'($urandom_range(1, A_DEPTH));
      nw = int'($urandom_range(1, na));
      st = int'($urandom_range(1, 15));
      for (int i = 0; i < na; i++) a_m[i] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < nw; i++) w_m[i] = int'($urandom_range(0, 255)) - 128;
      load_rows(na, nw);
      run_compute($sformatf("rand%0d", it), na, nw, st);
      run_sums($sformatf("rand%0d_sums", it), longint'($urandom_range(0, 524287)) - 262144, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_stride.md
# pe_stride

Parametrised successor processing element for the row-stationary array: performs a strided 1-D convolution of a locally stored activation row against a locally stored filter row, then streams partial sums to the systolic psum chain through a ready/valid handshake. It sits in the cluster under the multicast controller and is loaded with the same `ctrl_loadw`/`ctrl_loada` streaming protocol. New over the previous generation: configurable stride, parametrised scratchpad depths, configuration checking, an output backpressure handshake, and optional saturating accumulation.

## Interface
- `DATA_W`, 8: activation/weight width, signed.
- `A_DEPTH`, 16: activation scratchpad entries.
- `W_DEPTH`, 16: weight scratchpad entries.
- `PSUM_W`, 2*DATA_W+4: psum width, signed.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock.
- `nrst`  in  1  asynchronous active-low reset.
- `weights_i`  in  DATA_W  weight stream.
- `acts_i`  in  DATA_W  activation stream.
- `ctrl_loadw`, `ctrl_loada`  in  1 each  write the stream word this cycle.
- `ctrl_start`  in  1  begin compute.
- `ctrl_sums`  in  1  begin psum streaming.
- `cfg_acount`, `cfg_wcount`  in  8 each  row lengths, sampled at start.
- `cfg_stride`  in  4  convolution stride, sampled at start.
- `psum_i`  in  PSUM_W  upstream psum.
- `psum_valid_i`  in  1  `psum_i` valid.
- `psum_o`  out  PSUM_W  downstream psum; reset 0.
- `psum_valid_o`  out  1  reset 0.
- `psum_ready_i`  in  1  downstream accepts.
- `busy_o`  out  1  high outside IDLE; reset 0.
- `done_o`  out  1  one-cycle pulse; reset 0.
- `err_o`  out  1  one-cycle pulse on rejected start; reset 0.

## Operation
- States: IDLE, COMPUTE, DONE, SUMS. Reset enters IDLE and clears all counters, addresses and outputs; scratchpad contents are cleared.
- Load (IDLE only): each cycle with `ctrl_loadw` high writes `weights_i` to `w[waddr]`, then `waddr` increments; `waddr` returns to 0 on any cycle with `ctrl_loadw` low. The activation path behaves the same way with `ctrl_loada`. Writes are inhibited once the address reaches its depth, and the address holds there. Load strobes outside IDLE are ignored.
- Start (IDLE, `ctrl_start`, no load strobes active):
  - The start is rejected when `wcount==0`, `stride==0`, `wcount>acount`, `acount>A_DEPTH`, or `wcount>W_DEPTH`.
  - A rejected start pulses `err_o` the next cycle and the block stays in IDLE.
  - Otherwise the block computes `ocount = (acount-wcount)/stride + 1` (integer division) and enters COMPUTE.
- COMPUTE: one MAC per cycle, iterating k inner and o outer.
  - Each MAC computes `acc += a[o*stride+k]*w[k]`, with a full-precision 2*DATA_W product sign-extended to PSUM_W.
  - When k==wcount-1, `acc+product` is written to `s[o]` and `acc` is cleared.
  - After o==ocount-1 the block goes to DONE.
- DONE: `done_o`=1 for one cycle, then IDLE.
- SUMS (entered from IDLE on `ctrl_sums`, `idx`=0):
  - A transfer happens when `psum_valid_i && (!psum_valid_o || psum_ready_i)`. The block registers `psum_o = s[idx]+psum_i`, writes the same value back to `s[idx]`, sets `psum_valid_o`, and increments `idx`.
  - When `psum_valid_o && psum_ready_i` and no new transfer occurs, `psum_valid_o` clears.
  - After ocount transfers and a final handshake, the block pulses `done_o` and returns to IDLE.
- Simultaneous `ctrl_start` and `ctrl_sums`: start wins. `ctrl_sums` before any compute uses `ocount` from the last accepted start (0 after reset, which pulses `done_o` immediately).

## Timing
- Start sampled at cycle 0 → COMPUTE at cycles 1..ocount*wcount → `done_o` at cycle ocount*wcount+1.
- Sum result at output: 1 cycle after the transfer. `psum_o` and `psum_valid_o` are held stable while `psum_valid_o && !psum_ready_i`.
- Throughput in SUMS: 1 psum per cycle when `psum_valid_i` and `psum_ready_i` are held high.
- `nrst` low at any point, including mid-COMPUTE or mid-SUMS, resets immediately. No `done_o` is produced for the aborted operation.

## Configuration
- `PE_SAT_ACC_EN`, when defined: MAC accumulation and the SUMS addition saturate to [-2^(PSUM_W-1), 2^(PSUM_W-1)-1].
- When undefined: both wrap modulo 2^PSUM_W.

## Test plan
- Unit-stride convolution: load acts 1..5, weights 1,1,1, acount=5, wcount=3, stride=1, start → s={6,9,12}; `done_o` 10 cycles after start.
- Stride 2: acts 1..7, weights 1,0,-1, acount=7, wcount=3, stride=2 → ocount=3, s={-2,-2,-2}; `done_o` 10 cycles after start.
- Backpressure: after the first case, SUMS with `psum_i`=100 and `psum_ready_i` low for 2 cycles → `psum_o`=106 held with valid high; then 109 and 112; `done_o` pulses once.
- Saturation: acts/weights all -128, wcount=acount=16 (s[0]=262144), then SUMS with `psum_i`=300000 → 524287 with `PE_SAT_ACC_EN`; -486432 without.
- Rejected starts: wcount=0 → `err_o` pulse, `busy_o` stays 0; acount=3 with wcount=4 → `err_o` pulse.
- Reset mid-COMPUTE: assert `nrst` low at cycle 4 of the first case → all outputs 0 and state IDLE; re-load and start → correct results.
